// File: rtl/uart_tx_if.sv
// Producer-to-transmitter bus: word handshake in, serial line and queue status out.
// The producer side is the master; the transmitter is the slave.
interface uart_tx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]        in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        tx;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (output in_data, in_valid, input in_ready, tx, busy, fifo_count);
    modport slave  (input in_data, in_valid, output in_ready, tx, busy, fifo_count);
endinterface

// File: rtl/uart_tx.sv
// Queued UART serialiser: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// A word into an idle, empty queue starts its start bit one edge later; in_ready drops only when the queue is full.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 push, pop, fifo_empty;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [DATA_BITS-1:0] word, word_nxt;
    logic                 tx_q, tx_nxt, wrap;

    assign fifo_empty     = (count == '0);
    assign bus.in_ready   = (count != FULL_CNT);
    assign push           = bus.in_valid && bus.in_ready;
    assign bus.tx         = tx_q;
    assign bus.fifo_count = count;
    assign bus.busy       = (state != S_IDLE) || !fifo_empty;
    assign wrap           = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            word  <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            word  <= word_nxt;
            tx_q  <= tx_nxt;
        end
    end

    // Stop -> start pops in the same edge so back-to-back frames have no idle cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = S_START;
                    pop       = 1'b1;
                end
            end
            S_START:  if (wrap) state_nxt = S_DATA;
            S_DATA:   if (wrap && idx == DATA_LAST) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (wrap) state_nxt = S_STOP;
            S_STOP: begin
                if (wrap && idx == STOP_LAST) begin
                    if (!fifo_empty) begin
                        state_nxt = S_START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // tx is computed for the state being entered so the registered line changes on the transition edge.
    always_comb begin
        word_nxt = pop ? mem[rd_ptr] : word;
        cnt_nxt  = (state == S_IDLE || wrap) ? '0 : cnt + 1'b1;
        if (state_nxt != state) idx_nxt = '0;
        else if (wrap)          idx_nxt = idx + 1'b1;
        else                    idx_nxt = idx;
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = word[idx_nxt];
            S_PARITY: tx_nxt = (PARITY == 2) ? ^word : ~^word;
            default:  tx_nxt = 1'b1;
        endcase
    end
endmodule
